// File: rtl/reg_share_pkg.sv
// Shared types for the register-sharing arbiter.
// Holds the arbiter FSM state encoding.
package reg_share_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Round-robin picker: first unmasked request at or after ptr.
// Purely combinational; shared by the idle pick and the switch pick.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic [N-1:0]         excl,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [N-1:0] cand;

    // Scan from farthest to nearest so the nearest candidate wins.
    always_comb begin
        int j;
        j     = 0;
        cand  = req & ~excl;
        found = |cand;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (cand[j]) begin
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin owner of one shared W-bit register among N requesters.
// Owners may hold up to MAX_HOLD cycles while others wait.
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] owner,
    output logic [W-1:0]         q,
    output logic                 q_valid
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [HW-1:0] hold_cnt;

    logic [N-1:0]  own_mask;
    logic [IW-1:0] nxt_o;
    logic          own_req;
    logic          others;
    logic          expired;
    logic          keep;

    logic [IW-1:0] pick_ptr;
    logic [N-1:0]  pick_excl;
    logic          found;
    logic [IW-1:0] pidx;

    // Tenure status of the current owner and where the next search starts.
    always_comb begin
        own_mask  = N'(1) << owner;
        nxt_o     = (int'(owner) == N - 1) ? '0 : owner + 1'b1;
        own_req   = req[owner];
        others    = |(req & ~own_mask);
        expired   = hold_cnt >= HW'(MAX_HOLD);
        keep      = own_req && (!expired || !others);
        pick_ptr  = (state == IDLE) ? ptr : nxt_o;
        pick_excl = (state == IDLE) ? '0 : own_mask;
    end

    rr_pick #(
        .N(N)
    ) u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .excl (pick_excl),
        .found(found),
        .idx  (pidx)
    );

    // Arbiter FSM with registered grant, owner and shared register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            q        <= '0;
            q_valid  <= 1'b0;
            hold_cnt <= '0;
            ptr      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= N'(1) << pidx;
                        owner    <= pidx;
                        q        <= wdata[int'(pidx)*W +: W];
                        q_valid  <= 1'b1;
                        hold_cnt <= HW'(1);
                        state    <= GRANT;
                    end else begin
                        grant   <= '0;
                        q_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (keep) begin
                        q       <= wdata[int'(owner)*W +: W];
                        q_valid <= 1'b1;
                        if (!expired) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else if (others) begin
                        ptr      <= nxt_o;
                        grant    <= N'(1) << pidx;
                        owner    <= pidx;
                        q        <= wdata[int'(pidx)*W +: W];
                        q_valid  <= 1'b1;
                        hold_cnt <= HW'(1);
                    end else begin
                        ptr     <= nxt_o;
                        grant   <= '0;
                        q_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter.
// Directed scenarios plus randomized traffic against a reference model.
module tb_reg_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;
    localparam int IW = $clog2(N);

    typedef struct {
        logic [N-1:0]  g;
        logic [IW-1:0] o;
        logic [W-1:0]  d;
        logic          v;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   grant;
    logic [IW-1:0]  owner;
    logic [W-1:0]   q;
    logic           q_valid;

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;
    exp_t sb[$];

    bit       m_busy;
    int       m_own;
    int       m_ptr;
    int       m_hold;
    logic [W-1:0] m_q;

    always #5 clk = ~clk;

    reg_share_arbiter #(
        .N(N), .W(W), .MAX_HOLD(MH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .wdata  (wdata),
        .grant  (grant),
        .owner  (owner),
        .q      (q),
        .q_valid(q_valid)
    );

    function automatic int pick(logic [N-1:0] r, int start, int skip);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (r[j] && j != skip) return j;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] wd(int i);
        return wdata[i*W +: W];
    endfunction

    // Reference: advance one edge from the spec's rules.
    task automatic model_edge();
        int w;
        bit oth;
        if (reset) begin
            m_busy = 0; m_own = 0; m_ptr = 0;
            m_hold = 0; m_q = '0;
        end else if (!m_busy) begin
            w = pick(req, m_ptr, -1);
            if (w >= 0) begin
                m_busy = 1; m_own = w;
                m_q = wd(w); m_hold = 1;
            end
        end else begin
            oth = (req & ~(N'(1) << m_own)) != '0;
            if (req[m_own] && (m_hold < MH || !oth)) begin
                m_q = wd(m_own);
                if (m_hold < MH) m_hold++;
            end else if (oth) begin
                m_ptr = (m_own + 1) % N;
                w = pick(req, m_ptr, m_own);
                m_own = w; m_q = wd(w); m_hold = 1;
            end else begin
                m_busy = 0;
                m_ptr = (m_own + 1) % N;
            end
        end
    endtask

    task automatic step(logic [N-1:0] r, logic rst);
        exp_t e;
        req   = r;
        reset = rst;
        armed = 1'b1;
        model_edge();
        e.g = m_busy ? N'(1) << m_own : '0;
        e.o = IW'(m_own);
        e.d = m_q;
        e.v = m_busy;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(string nm, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic def_data();
        for (int i = 0; i < N; i++) wdata[i*W +: W] = W'(8'h10 + i);
    endtask

    // Monitor: pop expected response for every edge and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (armed) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_empty: got no expectation want one");
            end else begin
                e = sb.pop_front();
                if (grant !== e.g || q !== e.d || q_valid !== e.v ||
                    owner !== e.o) begin
                    fails++;
                    $display("FAIL sb @%0t: got g=%b o=%0d q=%h v=%b want g=%b o=%0d q=%h v=%b",
                             $time, grant, owner, q, q_valid,
                             e.g, e.o, e.d, e.v);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        reset = 1'b1;
        req   = '0;
        def_data();
        m_busy = 0; m_own = 0; m_ptr = 0; m_hold = 0; m_q = '0;
        @(negedge clk);

        // Reset with all requesting, then full rotation.
        for (int t = 0; t < 2; t++) begin
            step(4'b1111, 1'b1);
            chk("rst_grant", int'(grant), 0);
            chk("rst_q", int'(q), 0);
            chk("rst_v", int'(q_valid), 0);
        end
        for (int t = 0; t < 20; t++) begin
            step(4'b1111, 1'b0);
            chk("rr_grant", int'(grant), 1 << ((t / 4) % 4));
            chk("rr_q", int'(q), 8'h10 + (t / 4) % 4);
            chk("rr_owner", int'(owner), (t / 4) % 4);
        end

        // Lone requester is never forced off.
        step('0, 1'b1);
        wdata[2*W +: W] = 8'hA5;
        for (int t = 0; t < 6; t++) begin
            step(4'b0100, 1'b0);
            chk("lone_grant", int'(grant), 4'b0100);
            chk("lone_q", int'(q), 8'hA5);
        end
        def_data();

        // Release retains q/owner; next search starts after owner.
        step('0, 1'b1);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        chk("rel_grant", int'(grant), 0);
        chk("rel_v", int'(q_valid), 0);
        chk("rel_q", int'(q), 8'h11);
        chk("rel_owner", int'(owner), 1);
        step(4'b0011, 1'b0);
        chk("rel_next", int'(grant), 4'b0001);

        // Wrap from owner 3 and direct switch without bubble.
        step('0, 1'b1);
        step(4'b1000, 1'b0);
        step(4'b1001, 1'b0);
        step(4'b0001, 1'b0);
        chk("wrap_grant", int'(grant), 4'b0001);
        step('0, 1'b1);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0001, 1'b0);
        chk("sw_grant", int'(grant), 4'b0001);
        chk("sw_v", int'(q_valid), 1);

        // Reset during owner 2's third cycle.
        step('0, 1'b1);
        for (int t = 0; t < 11; t++) step(4'b1111, 1'b0);
        chk("mid_owner", int'(owner), 2);
        step(4'b1111, 1'b1);
        chk("mid_grant", int'(grant), 0);
        chk("mid_q", int'(q), 0);
        step(4'b1111, 1'b0);
        chk("mid_after", int'(grant), 4'b0001);

        // Randomized traffic.
        r = '0;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom);
            for (int i = 0; i < N; i++) wdata[i*W +: W] = W'($urandom);
            step(r, $urandom_range(0, 99) == 0);
        end

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_left: got %0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter that shares one W-bit storage register among N requesters. Each cycle it selects a requester, grants it ownership, and loads that requester's data into the register. An owner may keep the register for up to MAX_HOLD consecutive cycles; after that it is forced off if anyone else is waiting. It sits in front of the team's reset-able D flip-flop storage and sequences writes into it.

## Interface
Parameters:
- N, 4, number of requesters (≥2)
- W, 8, data width of shared register
- MAX_HOLD, 4, max consecutive cycles one owner holds grant while others wait (≥1)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  N  per-requester request, level-sensitive
- wdata  input  N*W  requester i data at bits [i*W +: W]
- grant  output  N  one-hot registered grant; 0 when idle
- owner  output  $clog2(N)  index of current or last owner
- q  output  W  shared register contents
- q_valid  output  1  high when q was written on the last edge (== |grant)

## Operation
- Reset (sampled at edge): state=IDLE, grant=0, owner=0, q=0, q_valid=0, hold_cnt=0, ptr=0. This gives requester 0 highest priority first. Reset overrides all other activity.
- Pick function: first i with req[i]=1, scanning ptr, ptr+1, … mod N.
- IDLE:
  - If any req, pick winner w.
    - Edge: grant=onehot(w), owner=w, q=wdata[w], q_valid=1, hold_cnt=1, state=GRANT.
  - Else everything holds, with grant=0 and q_valid=0.
- GRANT (owner o):
  - Keep:
    - Condition: req[o]=1 AND (hold_cnt<MAX_HOLD OR no other req).
    - Action: q=wdata[o]; hold_cnt=min(hold_cnt+1, MAX_HOLD).
  - Switch:
    - Condition: (req[o]=0 OR hold expired) AND another req exists.
    - Action: ptr=o+1 mod N; pick w excluding o; grant=onehot(w), owner=w, q=wdata[w], hold_cnt=1. No bubble cycle.
  - Release:
    - Condition: req[o]=0 AND no other req.
    - Action: grant=0, q_valid=0, q and owner retained, ptr=o+1 mod N, state=IDLE.
- Expired owner with others waiting is never re-picked on that edge, even if its req stays high.
- hold_cnt counts cycles held in the current tenure and saturates at MAX_HOLD.
- grant is always one-hot or zero. owner always equals the index of the set grant bit when grant≠0.

## Timing
- Latency req→grant/q: 1 edge (req sampled at edge k, grant and q visible after edge k).
- q updates only on edges where grant≠0 after the edge. Otherwise q holds.
- Max wait for a continuously requesting requester: (N-1)*MAX_HOLD cycles.
- Wrap-around: ptr increments mod N. Owner N-1 releasing starts the search at 0.
- Reset mid-tenure: the next edge gives grant=0, q=0, priority back to requester 0.
- Owner drops req on the same edge another asserts: Switch, not Release.

## Structure
- Shared package `reg_share_pkg`: state enum {IDLE, GRANT}; no other typedefs.
- One combinational sub-module `rr_pick`:
  - Parameter N.
  - Inputs: req, ptr, exclude-mask.
  - Outputs: found, idx.
  - Used for both IDLE pick and Switch pick.
- Top contains FSM, hold_cnt, ptr, owner, grant, and q registers.

## Test plan
N=4, W=8, MAX_HOLD=4, wdata[i]=8'h10+i unless stated.
- Reset, 2 cycles with req=4'b1111 → grant=0, q=0, q_valid=0 throughout. First edge after deassert → grant=0001, q=8'h10, owner=0.
- req=0100 only, wdata[2]=8'hA5, held 6 cycles → grant=0100 and q=A5 every cycle; no forced release.
- req=1111 held 20 cycles → grant sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001…; q tracks 10,11,12,13; no zero-grant cycle.
- Owner 1 holding, req→0000 → next edge grant=0, q_valid=0, q=8'h11 retained, owner=1. Then req=0011 → grant=0010? No: ptr=2 gives search 2,3,0 → grant=0001.
- Owner 3 releases with req=1001 pattern changing to 0001 → grant=0001 (wrap). Owner 2 drops while req[0] rises same cycle → direct switch to grant=0001, no idle cycle.
- Reset asserted during owner 2's 3rd cycle with req=1111 → grant=0, q=0. After deassert → grant=0001.
